// File: rtl/pic12f508_pkg.sv
// Shared types and constants for the PIC12F508 model: pin drive encoding,
// instruction-cycle phases, OPTION bit positions and default pin masks.
package pic12f508_pkg;

    localparam int unsigned IO_PINS = 6;
    localparam int unsigned OPT_W   = 8;

    localparam logic [IO_PINS-1:0] INPUT_ONLY_MASK_DEF = 6'b001000;
    localparam logic [IO_PINS-1:0] TRIS_RESET_DEF      = 6'b111111;
    localparam logic [IO_PINS-1:0] PULLUP_MASK_DEF     = 6'b001011;
    localparam logic [OPT_W-1:0]   OPTION_RESET        = 8'hFF;

    localparam int unsigned OPT_GPPU_N = 6;
    localparam int unsigned OPT_T0CS   = 5;
    localparam int unsigned GP_T0CKI   = 2;

    typedef enum logic [1:0] {
        PS_FLOAT = 2'd0,
        PS_LOW   = 2'd1,
        PS_HIGH  = 2'd2
    } pin_state_t;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_t;

endpackage

// File: rtl/gpio_stage_reg.sv
// Shadow register with pending flag; the shadow is copied to the live value
// on commit, and a write in the commit cycle itself is included.
module gpio_stage_reg
    import pic12f508_pkg::*;
#(
    parameter int unsigned   W         = 8,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic [W-1:0] wdata_i,
    input  logic         commit_i,
    output logic [W-1:0] live_o,
    output logic [W-1:0] live_next_c
);

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] live_q, live_d;
    logic         pending_q, pending_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= RESET_VAL;
            live_q    <= RESET_VAL;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        live_d    = live_q;
        if (we_i) begin
            shadow_d  = wdata_i;
            pending_d = 1'b1;
        end
        if (commit_i) begin
            pending_d = 1'b0;
            if (we_i || pending_q) begin
                live_d = shadow_d;
            end
        end
    end

    assign live_o      = live_q;
    assign live_next_c = live_d;

endmodule

// File: rtl/gpio_drive.sv
// GPIO output driver: stages GPIO/TRIS/OPTION writes, commits them once per
// instruction at Q4 and registers the resulting per-pin drive and pull-ups.
module gpio_drive
    import pic12f508_pkg::*;
#(
    parameter int unsigned          IO_PINS         = pic12f508_pkg::IO_PINS,
    parameter logic [IO_PINS-1:0]   INPUT_ONLY_MASK = INPUT_ONLY_MASK_DEF,
    parameter logic [IO_PINS-1:0]   TRIS_RESET      = TRIS_RESET_DEF,
    parameter logic [IO_PINS-1:0]   PULLUP_MASK     = PULLUP_MASK_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gpio_we,
    input  logic [7:0]             gpio_wdata,
    input  logic                   tris_we,
    input  logic [7:0]             tris_wdata,
    input  logic                   option_we,
    input  logic [7:0]             option_wdata,
    output logic [1:0]             q_phase,
    output logic                   commit,
    output logic [IO_PINS-1:0]     latch,
    output logic [2*IO_PINS-1:0]   pin_state,
    output logic [IO_PINS-1:0]     pin_pu
);

    q_phase_t             phase_q, phase_d;
    logic                 commit_q;
    logic                 commit_now_c;
    logic [2*IO_PINS-1:0] pin_state_q, pin_state_d;
    logic [IO_PINS-1:0]   pin_pu_q, pin_pu_d;
    logic [IO_PINS-1:0]   oe_c;

    logic [IO_PINS-1:0]   gpio_live, gpio_nx;
    logic [IO_PINS-1:0]   tris_live_unused, tris_nx;
    logic [OPT_W-1:0]     opt_live_unused, opt_nx;
    logic                 unused_ok_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= Q1;
            commit_q    <= 1'b0;
            pin_state_q <= '0;
            pin_pu_q    <= '0;
        end else begin
            phase_q     <= phase_d;
            commit_q    <= (phase_d == Q4);
            pin_state_q <= pin_state_d;
            pin_pu_q    <= pin_pu_d;
        end
    end

    // Free-running Q1..Q4 instruction-cycle sequencer
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            Q1:      phase_d = Q2;
            Q2:      phase_d = Q3;
            Q3:      phase_d = Q4;
            Q4:      phase_d = Q1;
            default: phase_d = Q1;
        endcase
    end

    assign commit_now_c = (phase_q == Q4);

    gpio_stage_reg #(.W(IO_PINS), .RESET_VAL('0)) u_gpio (
        .clk         (clk),
        .rst         (rst),
        .we_i        (gpio_we),
        .wdata_i     (gpio_wdata[IO_PINS-1:0]),
        .commit_i    (commit_now_c),
        .live_o      (gpio_live),
        .live_next_c (gpio_nx)
    );

    gpio_stage_reg #(.W(IO_PINS), .RESET_VAL(TRIS_RESET)) u_tris (
        .clk         (clk),
        .rst         (rst),
        .we_i        (tris_we),
        .wdata_i     (tris_wdata[IO_PINS-1:0]),
        .commit_i    (commit_now_c),
        .live_o      (tris_live_unused),
        .live_next_c (tris_nx)
    );

    gpio_stage_reg #(.W(OPT_W), .RESET_VAL(OPTION_RESET)) u_option (
        .clk         (clk),
        .rst         (rst),
        .we_i        (option_we),
        .wdata_i     (option_wdata),
        .commit_i    (commit_now_c),
        .live_o      (opt_live_unused),
        .live_next_c (opt_nx)
    );

    // Drive is derived from the post-commit values so it lands with the latch
    always_comb begin
        oe_c        = '0;
        pin_state_d = '0;
        pin_pu_d    = '0;
        for (int unsigned i = 0; i < IO_PINS; i++) begin
            oe_c[i] = ~tris_nx[i] & ~INPUT_ONLY_MASK[i]
                    & ~(opt_nx[OPT_T0CS] & (i == GP_T0CKI));
            if (oe_c[i]) begin
                pin_state_d[2*i +: 2] = gpio_nx[i] ? PS_HIGH : PS_LOW;
            end else begin
                pin_state_d[2*i +: 2] = PS_FLOAT;
            end
            pin_pu_d[i] = ~opt_nx[OPT_GPPU_N] & PULLUP_MASK[i] & ~oe_c[i];
        end
    end

    assign unused_ok_c = ^{gpio_wdata[7:IO_PINS], tris_wdata[7:IO_PINS],
                           opt_nx[7], opt_nx[4:0], tris_live_unused, opt_live_unused};

    assign q_phase   = phase_q;
    assign commit    = commit_q;
    assign latch     = gpio_live;
    assign pin_state = pin_state_q;
    assign pin_pu    = pin_pu_q;

endmodule

// File: tb/tb_gpio_drive.sv
// Bench for gpio_drive: directed scenarios with literal expectations, then
// random strobes and resets checked every cycle against an instruction-level model.
module tb_gpio_drive;

    logic        clk;
    logic        rst;
    logic        gpio_we, tris_we, option_we;
    logic [7:0]  gpio_wdata, tris_wdata, option_wdata;
    logic [1:0]  q_phase;
    logic        commit;
    logic [5:0]  latch;
    logic [11:0] pin_state;
    logic [5:0]  pin_pu;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_drive dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_we      (gpio_we),
        .gpio_wdata   (gpio_wdata),
        .tris_we      (tris_we),
        .tris_wdata   (tris_wdata),
        .option_we    (option_we),
        .option_wdata (option_wdata),
        .q_phase      (q_phase),
        .commit       (commit),
        .latch        (latch),
        .pin_state    (pin_state),
        .pin_pu       (pin_pu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction-level model: index 0 = GPIO, 1 = TRIS, 2 = OPTION
    int       m_phase = 0;
    bit [7:0] m_sh   [3] = '{8'h00, 8'h3F, 8'hFF};
    bit [7:0] m_live [3] = '{8'h00, 8'h3F, 8'hFF};
    bit       m_pend [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_sh    = '{8'h00, 8'h3F, 8'hFF};
            m_live  = '{8'h00, 8'h3F, 8'hFF};
            m_pend  = '{1'b0, 1'b0, 1'b0};
        end else begin
            if (gpio_we)   begin m_sh[0] = gpio_wdata & 8'h3F; m_pend[0] = 1'b1; end
            if (tris_we)   begin m_sh[1] = tris_wdata & 8'h3F; m_pend[1] = 1'b1; end
            if (option_we) begin m_sh[2] = option_wdata;       m_pend[2] = 1'b1; end
            if (m_phase == 3) begin
                for (int k = 0; k < 3; k++) begin
                    if (m_pend[k]) m_live[k] = m_sh[k];
                    m_pend[k] = 1'b0;
                end
            end
            m_phase = (m_phase + 1) % 4;
        end
    end

    function automatic bit drives(input int i, input bit [7:0] tr, input bit [7:0] op);
        return !tr[i] && (i != 3) && !(op[5] && i == 2);
    endfunction

    function automatic logic [11:0] exp_pins(input bit [7:0] lat, input bit [7:0] tr,
                                             input bit [7:0] op);
        logic [11:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            if (drives(i, tr, op)) r[2*i +: 2] = lat[i] ? 2'd2 : 2'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] exp_pu(input bit [7:0] tr, input bit [7:0] op);
        logic [5:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i] = !op[6] && (i == 0 || i == 1 || i == 3) && !drives(i, tr, op);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_phase",  32'(q_phase),   32'(m_phase));
        chk("m_commit", 32'(commit),    32'(m_phase == 3));
        chk("m_latch",  32'(latch),     32'(m_live[0][5:0]));
        chk("m_pins",   32'(pin_state), 32'(exp_pins(m_live[0], m_live[1], m_live[2])));
        chk("m_pu",     32'(pin_pu),    32'(exp_pu(m_live[1], m_live[2])));
    end

    task automatic wait_phase(input int p);
        for (int n = 0; n < 8 && m_phase != p; n++) begin
            @(posedge clk);
            #1;
        end
        if (m_phase != p) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase actual=%0d required=%0d", m_phase, p);
        end
    endtask

    task automatic drive(input bit gw, input bit [7:0] gd, input bit tw, input bit [7:0] td,
                         input bit ow, input bit [7:0] od);
        gpio_we = gw; gpio_wdata = gd;
        tris_we = tw; tris_wdata = td;
        option_we = ow; option_wdata = od;
        @(posedge clk);
        #1;
        gpio_we = 1'b0; tris_we = 1'b0; option_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        gpio_we = 1'b0; tris_we = 1'b0; option_we = 1'b0;
        gpio_wdata = '0; tris_wdata = '0; option_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_phase",  32'(q_phase),   32'd0);
        chk("rst_commit", 32'(commit),    32'd0);
        chk("rst_pins",   32'(pin_state), 32'h000);
        chk("rst_pu",     32'(pin_pu),    32'h00);

        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("first_commit_pulse", 32'(commit), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("first_commit_latch", 32'(latch),     32'h00);
        chk("first_commit_pins",  32'(pin_state), 32'h000);

        // T0CS cleared, then TRIS 00 + GPIO FF in Q2 of the same instruction
        wait_phase(0);
        drive(0, 8'h00, 0, 8'h00, 1, 8'hDF);
        wait_phase(1);
        drive(1, 8'hFF, 1, 8'h00, 0, 8'h00);
        wait_phase(0);
        @(negedge clk);
        chk("all_out_latch", 32'(latch),     32'h3F);
        chk("all_out_pins",  32'(pin_state), 32'hA2A);

        wait_phase(0);
        drive(1, 8'h04, 0, 8'h00, 0, 8'h00);
        wait_phase(0);
        @(negedge clk);
        chk("gp2_high_pins", 32'(pin_state), 32'h525);

        drive(0, 8'h00, 0, 8'h00, 1, 8'hFF);
        wait_phase(0);
        @(negedge clk);
        chk("t0cs_gp2_pins",  32'(pin_state), 32'h505);
        chk("t0cs_gp2_latch", 32'(latch),     32'h04);

        // Two GPIO writes in one instruction: last one wins, visible at next Q1
        drive(1, 8'h01, 0, 8'h00, 0, 8'h00);
        drive(1, 8'h02, 0, 8'h00, 0, 8'h00);
        wait_phase(3);
        @(negedge clk);
        chk("lastwin_q4_pins", 32'(pin_state), 32'h505);
        wait_phase(0);
        @(negedge clk);
        chk("lastwin_pins",  32'(pin_state), 32'h509);
        chk("lastwin_latch", 32'(latch),     32'h02);

        drive(0, 8'h00, 1, 8'h3E, 1, 8'h9F);
        wait_phase(0);
        @(negedge clk);
        chk("pullup_pu",   32'(pin_pu),    32'h0A);
        chk("pullup_pins", 32'(pin_state), 32'h001);

        // GPIO write and reset pulse in the same Q3
        wait_phase(2);
        gpio_we = 1'b1; gpio_wdata = 8'h3F; rst = 1'b1;
        @(posedge clk); #1;
        gpio_we = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rstmid_latch", 32'(latch),   32'h00);
        chk("rstmid_phase", 32'(q_phase), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstmid_commit", 32'(commit), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_after_latch", 32'(latch), 32'h00);

        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            gpio_we      = ($urandom % 3) == 0;
            gpio_wdata   = 8'($urandom);
            tris_we      = ($urandom % 4) == 0;
            tris_wdata   = 8'($urandom);
            option_we    = ($urandom % 5) == 0;
            option_wdata = 8'($urandom);
            rst          = ($urandom % 80) == 0;
        end
        @(posedge clk); #1;
        gpio_we = 1'b0; tris_we = 1'b0; option_we = 1'b0; rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
